// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module  : wb_arbiter_pkg
// Purpose : Shared definitions for the write-back arbiter slice. This file
//           holds the AWIDTH / DWIDTH definitions that the rest of the
//           pipeline includes, plus the lane type and the saturating
//           counter helper.
// Ports   : none (package)
// Config  : WB_BYPASS_EN (see wb_arbiter) -- not referenced here
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

package wb_arbiter_pkg;

  localparam int unsigned WA_AWIDTH = `AWIDTH;
  localparam int unsigned WA_DWIDTH = `DWIDTH;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // Saturating increment for the 16-bit conflict counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_des.sv
// ============================================================================
// Module  : mux_des
// Purpose : Destination register select: rd when sel_i=1, rt when sel_i=0.
// Ports   : sel_i (reg_dst), a1_i (rd), a0_i (rt), y_o (destination)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_des #(
  parameter int unsigned W = 5
) (
  input  logic         sel_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] a0_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? a1_i : a0_i;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter_fifo.sv
// ============================================================================
// Module  : wb_fifo
// Purpose : Per-lane result FIFO, DEPTH entries of WIDTH bits, first-word
//           fall-through head.
// Ports   : clk_i, rst_ni (async, active-low), push_i, pop_i, wdata_i,
//           rdata_o (head), count_o, full_o, empty_o
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module  : wb_arbiter
// Purpose : Shares the single register-file write port between two
//           execution lanes. Each lane resolves rd/rt, buffers stored
//           results in a wb_fifo, and the heads are granted round-robin
//           into a registered write port.
// Ports   : wa_i_clk, wa_i_rst_n (async, active-low)
//           lane k (k=0,1): wa_i_valid_k, wa_o_ready_k, wa_i_reg_write_k,
//             wa_i_reg_dst_k, wa_i_addr_rd_k, wa_i_addr_rt_k, wa_i_data_k
//           write port: wa_o_we, wa_o_addr, wa_o_data
//           status: wa_o_busy, wa_o_conflicts (16-bit saturating)
// Config  : WB_BYPASS_EN - an empty lane's stored input may be granted in
//           the handshake cycle, skipping the FIFO (1-cycle latency).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned AWIDTH = `AWIDTH,
  parameter int unsigned DWIDTH = `DWIDTH
) (
  input  logic              wa_i_clk,
  input  logic              wa_i_rst_n,
  input  logic              wa_i_valid_0,
  output logic              wa_o_ready_0,
  input  logic              wa_i_reg_write_0,
  input  logic              wa_i_reg_dst_0,
  input  logic [AWIDTH-1:0] wa_i_addr_rd_0,
  input  logic [AWIDTH-1:0] wa_i_addr_rt_0,
  input  logic [DWIDTH-1:0] wa_i_data_0,
  input  logic              wa_i_valid_1,
  output logic              wa_o_ready_1,
  input  logic              wa_i_reg_write_1,
  input  logic              wa_i_reg_dst_1,
  input  logic [AWIDTH-1:0] wa_i_addr_rd_1,
  input  logic [AWIDTH-1:0] wa_i_addr_rt_1,
  input  logic [DWIDTH-1:0] wa_i_data_1,
  output logic              wa_o_we,
  output logic [AWIDTH-1:0] wa_o_addr,
  output logic [DWIDTH-1:0] wa_o_data,
  output logic              wa_o_busy,
  output logic [15:0]       wa_o_conflicts
);

  localparam int unsigned EW = AWIDTH + DWIDTH;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]        valid, reg_write, reg_dst;
  logic [1:0]        ready, store, hs, push, pop, byp_use, cand, empty, full;
  logic [AWIDTH-1:0] addr_rd [2];
  logic [AWIDTH-1:0] addr_rt [2];
  logic [AWIDTH-1:0] dest    [2];
  logic [DWIDTH-1:0] data_in [2];
  logic [EW-1:0]     head    [2];
  logic [CW-1:0]     count   [2];

  logic              gnt, gnt_sel;
  lane_e             last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [15:0]       conflicts_q, conflicts_d;

  assign valid     = {wa_i_valid_1, wa_i_valid_0};
  assign reg_write = {wa_i_reg_write_1, wa_i_reg_write_0};
  assign reg_dst   = {wa_i_reg_dst_1, wa_i_reg_dst_0};
  assign addr_rd[0] = wa_i_addr_rd_0;
  assign addr_rd[1] = wa_i_addr_rd_1;
  assign addr_rt[0] = wa_i_addr_rt_0;
  assign addr_rt[1] = wa_i_addr_rt_1;
  assign data_in[0] = wa_i_data_0;
  assign data_in[1] = wa_i_data_1;

  for (genvar k = 0; k < 2; k++) begin : g_lane
    mux_des #(.W(AWIDTH)) u_mux_des (
      .sel_i (reg_dst[k]),
      .a1_i  (addr_rd[k]),
      .a0_i  (addr_rt[k]),
      .y_o   (dest[k])
    );

    // Non-writing results and writes to $zero consume the handshake only.
    assign store[k] = reg_write[k] & (dest[k] != '0);
    assign ready[k] = ~full[k];
    assign hs[k]    = valid[k] & ready[k];

`ifdef WB_BYPASS_EN
    assign cand[k] = ~empty[k] | (valid[k] & store[k]);
`else
    assign cand[k] = ~empty[k];
`endif

    // A grant to an empty lane can only be a bypass of the live input.
    assign pop[k]     = gnt & (gnt_sel == 1'(k)) & ~empty[k];
    assign byp_use[k] = gnt & (gnt_sel == 1'(k)) & empty[k];
    assign push[k]    = hs[k] & store[k] & ~byp_use[k];

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
      .clk_i   (wa_i_clk),
      .rst_ni  (wa_i_rst_n),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .wdata_i ({dest[k], data_in[k]}),
      .rdata_o (head[k]),
      .count_o (count[k]),
      .full_o  (full[k]),
      .empty_o (empty[k])
    );
  end

  always_comb begin
    gnt          = 1'b0;
    gnt_sel      = 1'b0;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    conflicts_d  = conflicts_q;

    if (cand == 2'b11) begin
      gnt         = 1'b1;
      gnt_sel     = (last_grant_q == LANE1) ? 1'b0 : 1'b1;
      conflicts_d = sat_inc16(conflicts_q);
    end else if (cand[0]) begin
      gnt     = 1'b1;
      gnt_sel = 1'b0;
    end else if (cand[1]) begin
      gnt     = 1'b1;
      gnt_sel = 1'b1;
    end

    if (gnt) begin
      last_grant_d = lane_e'(gnt_sel);
      we_d         = 1'b1;
      if (empty[gnt_sel]) begin
        addr_d = dest[gnt_sel];
        data_d = data_in[gnt_sel];
      end else begin
        {addr_d, data_d} = head[gnt_sel];
      end
    end
  end

  always_ff @(posedge wa_i_clk or negedge wa_i_rst_n) begin
    if (!wa_i_rst_n) begin
      last_grant_q <= LANE1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      conflicts_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      conflicts_q  <= conflicts_d;
    end
  end

  assign wa_o_ready_0   = ready[0];
  assign wa_o_ready_1   = ready[1];
  assign wa_o_we        = we_q;
  assign wa_o_addr      = addr_q;
  assign wa_o_data      = data_q;
  assign wa_o_conflicts = conflicts_q;
  assign wa_o_busy      = (count[0] != '0) | (count[1] != '0) | we_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module  : tb_wb_arbiter
// Purpose : Self-checking bench for wb_arbiter: directed vector table,
//           hand-written conflict / reset / saturation sequences, and
//           random traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int AW    = WA_AWIDTH;
  localparam int DW    = WA_DWIDTH;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic          clk, rst_n;
  logic          v   [2];
  logic          rw  [2];
  logic          dst [2];
  logic [AW-1:0] rd  [2];
  logic [AW-1:0] rt  [2];
  logic [DW-1:0] d   [2];
  logic          rdy0, rdy1, we, busy;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [15:0]   conf;

  wb_arbiter #(.DEPTH(DEPTH), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .wa_i_clk         (clk),
    .wa_i_rst_n       (rst_n),
    .wa_i_valid_0     (v[0]),
    .wa_o_ready_0     (rdy0),
    .wa_i_reg_write_0 (rw[0]),
    .wa_i_reg_dst_0   (dst[0]),
    .wa_i_addr_rd_0   (rd[0]),
    .wa_i_addr_rt_0   (rt[0]),
    .wa_i_data_0      (d[0]),
    .wa_i_valid_1     (v[1]),
    .wa_o_ready_1     (rdy1),
    .wa_i_reg_write_1 (rw[1]),
    .wa_i_reg_dst_1   (dst[1]),
    .wa_i_addr_rd_1   (rd[1]),
    .wa_i_addr_rt_1   (rt[1]),
    .wa_i_data_1      (d[1]),
    .wa_o_we          (we),
    .wa_o_addr        (addr),
    .wa_o_data        (data),
    .wa_o_busy        (busy),
    .wa_o_conflicts   (conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; rw[k] = 1'b0; dst[k] = 1'b0;
      rd[k] = '0; rt[k] = '0; d[k] = '0;
    end
  endtask

  // ---------------- reference model (queues of pending writes) -------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] dat;
  } ent_t;

  ent_t          q0[$];
  ent_t          q1[$];
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_conf;
  int            m_last;
  bit            hs_last [2];

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_we = 0; m_addr = '0; m_data = '0; m_conf = 0; m_last = 1;
    hs_last[0] = 0; hs_last[1] = 0;
  endtask

  // One clock edge worth of behaviour, from the inputs as they stood.
  task automatic model_step();
    int   sz0, sz1, g;
    bit   h0, h1, s0, s1, c0, c1;
    ent_t e0, e1, o;
    sz0 = q0.size(); sz1 = q1.size();
    h0 = v[0] && (sz0 < DEPTH);
    h1 = v[1] && (sz1 < DEPTH);
    e0.a = dst[0] ? rd[0] : rt[0]; e0.dat = d[0];
    e1.a = dst[1] ? rd[1] : rt[1]; e1.dat = d[1];
    s0 = h0 && rw[0] && (e0.a != 0);
    s1 = h1 && rw[1] && (e1.a != 0);
    c0 = (sz0 > 0) || (BYP && s0);
    c1 = (sz1 > 0) || (BYP && s1);
    g = -1;
    if (c0 && c1) begin
      g = (m_last == 0) ? 1 : 0;
      if (m_conf < 65535) m_conf++;
    end else if (c0) g = 0;
    else if (c1) g = 1;
    m_we = 0;
    if (g == 0) begin
      if (sz0 > 0) o = q0.pop_front();
      else begin o = e0; s0 = 0; end
    end else if (g == 1) begin
      if (sz1 > 0) o = q1.pop_front();
      else begin o = e1; s1 = 0; end
    end
    if (g >= 0) begin
      m_we = 1; m_addr = o.a; m_data = o.dat; m_last = g;
    end
    if (s0) q0.push_back(e0);
    if (s1) q1.push_back(e1);
    hs_last[0] = h0; hs_last[1] = h1;
  endtask

  task automatic model_compare();
    chk("we",     64'(we),   64'(m_we));
    chk("addr",   64'(addr), 64'(m_addr));
    chk("data",   64'(data), 64'(m_data));
    chk("conf",   64'(conf), 64'(m_conf));
    chk("ready0", 64'(rdy0), 64'(q0.size() < DEPTH));
    chk("ready1", 64'(rdy1), 64'(q1.size() < DEPTH));
    chk("busy",   64'(busy), 64'(q0.size() > 0 || q1.size() > 0 || m_we));
  endtask

  // mode 0: random traffic; mode 1: both lanes stream stored results
  int seq_data = 1;
  task automatic run_model(input int cycles, input int mode);
    for (int c = 0; c < cycles; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(v[k] && !hs_last[k])) begin
          if (mode == 1) begin
            v[k] = 1'b1; rw[k] = 1'b1; dst[k] = 1'b1;
            rd[k] = AW'(k + 1); rt[k] = '0;
            d[k] = DW'(seq_data); seq_data++;
          end else begin
            v[k]   = ($urandom_range(0, 9) < 6);
            rw[k]  = ($urandom_range(0, 9) < 8);
            dst[k] = 1'($urandom_range(0, 1));
            rd[k]  = AW'($urandom_range(0, 7));
            rt[k]  = AW'($urandom_range(0, 31));
            d[k]   = DW'($urandom());
          end
        end
      end
      @(posedge clk);
      model_step();
      #1;
      model_compare();
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    int            lane;
    bit            rw;
    bit            dst;
    logic [AW-1:0] rd;
    logic [AW-1:0] rt;
    logic [DW-1:0] dat;
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{0, 1'b1, 1'b1, 5'd5,  5'd7,  32'h0000_00A5, 1'b1, 5'd5,  32'h0000_00A5};
    vt[1] = '{1, 1'b1, 1'b0, 5'd3,  5'd10, 32'h0000_1234, 1'b1, 5'd10, 32'h0000_1234};
    vt[2] = '{0, 1'b0, 1'b1, 5'd6,  5'd7,  32'h0000_BEEF, 1'b0, 5'd0,  32'h0};
    vt[3] = '{1, 1'b1, 1'b1, 5'd0,  5'd9,  32'h0000_CAFE, 1'b0, 5'd0,  32'h0};
    vt[4] = '{1, 1'b1, 1'b1, 5'd31, 5'd2,  32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vt[5] = '{0, 1'b1, 1'b0, 5'd9,  5'd0,  32'h0000_0077, 1'b0, 5'd0,  32'h0};

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    chk("reset_we",     64'(we),   64'd0);
    chk("reset_addr",   64'(addr), 64'd0);
    chk("reset_data",   64'(data), 64'd0);
    chk("reset_busy",   64'(busy), 64'd0);
    chk("reset_conf",   64'(conf), 64'd0);
    chk("reset_ready0", 64'(rdy0), 64'd1);
    chk("reset_ready1", 64'(rdy1), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      v[vt[i].lane]   = 1'b1;
      rw[vt[i].lane]  = vt[i].rw;
      dst[vt[i].lane] = vt[i].dst;
      rd[vt[i].lane]  = vt[i].rd;
      rt[vt[i].lane]  = vt[i].rt;
      d[vt[i].lane]   = vt[i].dat;
      tick();
      idle_inputs();
      repeat (LAT - 1) tick();
      chk($sformatf("vec%0d_we", i), 64'(we), 64'(vt[i].exp_we));
      if (vt[i].exp_we) begin
        chk($sformatf("vec%0d_addr", i), 64'(addr), 64'(vt[i].exp_addr));
        chk($sformatf("vec%0d_data", i), 64'(data), 64'(vt[i].exp_data));
      end
      tick();
      chk($sformatf("vec%0d_we_drop", i), 64'(we), 64'd0);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
    end

    // Backpressure: both lanes stream for 10 cycles under the model.
    apply_reset();
    run_model(10, 1);

    // Reset mid-stream with full FIFOs; asynchronous clear between edges.
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",     64'(we),   64'd0);
    chk("mid_rst_addr",   64'(addr), 64'd0);
    chk("mid_rst_data",   64'(data), 64'd0);
    chk("mid_rst_conf",   64'(conf), 64'd0);
    chk("mid_rst_busy",   64'(busy), 64'd0);
    chk("mid_rst_ready0", 64'(rdy0), 64'd1);
    chk("mid_rst_ready1", 64'(rdy1), 64'd1);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_we", 64'(we), 64'd0);

    // Conflict: lane0 data 1 must be written before lane1 data 2.
    v[0] = 1'b1; rw[0] = 1'b1; dst[0] = 1'b1; rd[0] = 5'd3; d[0] = 32'd1;
    v[1] = 1'b1; rw[1] = 1'b1; dst[1] = 1'b1; rd[1] = 5'd4; d[1] = 32'd2;
    tick();
    idle_inputs();
    repeat (LAT - 1) tick();
    chk("conf_first_we",   64'(we),   64'd1);
    chk("conf_first_addr", 64'(addr), 64'd3);
    chk("conf_first_data", 64'(data), 64'd1);
    tick();
    chk("conf_second_we",   64'(we),   64'd1);
    chk("conf_second_addr", 64'(addr), 64'd4);
    chk("conf_second_data", 64'(data), 64'd2);
    chk("conf_count",       64'(conf), 64'd1);
    tick();
    chk("conf_idle_we",   64'(we),   64'd0);
    chk("conf_idle_busy", 64'(busy), 64'd0);

    // Random traffic against the reference model.
    apply_reset();
    run_model(1500, 0);

    // Saturation: keep both lanes permanently busy.
    apply_reset();
    v[0] = 1'b1; rw[0] = 1'b1; dst[0] = 1'b1; rd[0] = 5'd1; d[0] = 32'h11;
    v[1] = 1'b1; rw[1] = 1'b1; dst[1] = 1'b1; rd[1] = 5'd2; d[1] = 32'h22;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_conf", 64'(conf), 64'hFFFF);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
